// File: rtl/uart_tx_frame.sv
// UART transmitter: one 8N-odd-parity-1 frame per accepted send request,
// LSB first, fixed baud, with registered tx_out/busy and a one-frame-per-hold handshake.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 19_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx_out,
  output logic       busy
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int TMR_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BAUD_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BITS  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;

  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       idx;
  logic [7:0]       data;
  logic             parity;
  logic             bit_end;
  logic             start;

  assign bit_end = (timer == TMR_LAST);
  assign start   = (state == S_IDLE) && send;

  // Byte and parity are only meaningful once a frame starts, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      data   <= din;
      parity <= ~^din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      timer  <= '0;
      idx    <= 3'd0;
      tx_out <= 1'b1;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          timer  <= '0;
          idx    <= 3'd0;
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (send) begin
            state  <= S_START;
            tx_out <= 1'b0;
            busy   <= 1'b1;
          end
        end
        S_START: begin
          timer <= bit_end ? '0 : timer + 1'b1;
          if (bit_end) begin
            state  <= S_BITS;
            tx_out <= data[0];
          end
        end
        S_BITS: begin
          timer <= bit_end ? '0 : timer + 1'b1;
          if (bit_end) begin
            if (idx == 3'd7) begin
              state  <= S_PAR;
              tx_out <= parity;
            end else begin
              idx    <= idx + 3'd1;
              tx_out <= data[idx + 3'd1];
            end
          end
        end
        S_PAR: begin
          timer <= bit_end ? '0 : timer + 1'b1;
          if (bit_end) begin
            state  <= S_STOP;
            tx_out <= 1'b1;
          end
        end
        S_STOP: begin
          timer <= bit_end ? '0 : timer + 1'b1;
          // A still-held send parks in ACK so one hold yields one frame.
          if (bit_end) begin
            busy  <= 1'b0;
            state <= send ? S_ACK : S_IDLE;
          end
        end
        S_ACK: begin
          tx_out <= 1'b1;
          busy   <= 1'b0;
          if (!send) state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          timer  <= '0;
          idx    <= 3'd0;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter for the UART datapath: accepts a byte over a level send/busy handshake and shifts it out as one 8-data-bit, odd-parity, one-stop-bit frame at a fixed baud rate. It sits between the byte source (a debounced, one-shot button path or a control FSM) and the board's serial TX pin. It is the transmit end of the same line the UART receiver consumes.

## Interface
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- BAUD_RATE, 19_200, line bit rate in bits/s; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer truncation; 5208 at defaults)
- clk  input  1  system clock; all state on posedge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- send  input  1  level request; a frame starts when send=1 while idle
- din  input  8  byte to transmit; sampled only on the start edge
- tx_out  output  1  serial line, idle high; registered, glitch-free
- busy  output  1  high while a frame is on the line (START..STOP)

## Operation
- States: IDLE, START, BITS, PAR, STOP, ACK.
- IDLE: tx_out=1, busy=0. On a clk edge with send=1: latch din into shift register, compute odd parity (parity bit = ~^din), clear bit timer and bit index, go to START.
- START: tx_out=0 for BAUD_DIV cycles, then BITS.
- BITS: tx_out = din[idx], idx 0..7 (LSB first), each held BAUD_DIV cycles; after idx 7 go to PAR.
- PAR: tx_out = parity bit for BAUD_DIV cycles, then STOP.
- STOP: tx_out=1 for BAUD_DIV cycles; at end go to IDLE if send=0, else ACK.
- ACK: tx_out=1, busy=0; stay until send=0, then IDLE. A held send produces exactly one frame.
- Bit timer: counts 0..BAUD_DIV-1, wraps and advances bit on terminal count; width = $clog2(BAUD_DIV). Bit index: 3 bits.
- din changes after the start edge are ignored; the latched copy is transmitted.
- send pulses while busy=1 are ignored (not queued).
- Odd parity: total count of ones in data+parity bit is odd (0x00 -> 1, 0x07 -> 0, 0xFF -> 1).

## Timing
- Reset (reset=0, asynchronous): state IDLE, tx_out=1, busy=0, timer and index cleared. Takes effect immediately, including mid-frame; line returns high without finishing the frame.
- Reset release: first frame can start on the first clk edge with reset=1 and send=1.
- Latency: send sampled at edge N -> tx_out=0 and busy=1 from edge N (registered outputs, visible after edge N).
- Frame length: exactly 11*BAUD_DIV cycles from tx_out falling to the end of the stop bit; every bit is exactly BAUD_DIV cycles.
- busy falls on the edge that ends the stop bit; if send=0 at that edge, a new send is accepted on the next edge (minimum 1 idle cycle between frames, stop bit never shortened).
- tx_out and busy are driven directly from flops; no combinational path from send/din to outputs.

## Test plan
- Reset: hold reset=0 with send=1, din=0xAA -> tx_out=1, busy=0 throughout; assert reset mid-frame -> tx_out=1, busy=0 immediately.
- Single frame (CLK_FREQ=1000, BAUD_RATE=100, BAUD_DIV=10): send 1-cycle pulse with din=0x41 -> tx_out sequence 0,1,0,0,0,0,0,1,0,1,1, each 10 cycles; busy high for exactly 110 cycles.
- Parity: din=0x07 -> parity bit 0; din=0x00 -> 1; din=0xFF -> 1; check stop bit 1 in all cases.
- Held send: keep send=1 for 300 cycles with din=0x55 -> exactly one frame, busy low in ACK, no second start bit until send drops and is reasserted.
- din stability: change din from 0x41 to 0xFF one cycle after start -> line still carries 0x41 with parity 1.
- Back-to-back: drop send during the frame, raise it on the cycle busy falls -> second frame's start bit begins no earlier than one cycle after the first stop bit completes; stop bit remains 10 cycles.
